alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised, handshaked successor to the combinational datapath ALU. Accepts one
//  operation per valid/ready transfer and computes it in 1..W cycles: serial barrel
//  shift by full amount, shift-add multiply. Returns a registered result with
//  Zero/Carry/Err flags. Sits between decode/regfile read and writeback; the core
//  stalls on in_ready/out_valid.
// PARAMETERS
//  W   8            datapath width; power of two, >= 4
//  SW  $clog2(W)    derived (localparam): shift-amount width; B[SW] = shift direction
// PORTS
//  Clk        in   1   clock, all state updates on rising edge
//  Reset_n    in   1   asynchronous, active-low reset
//  in_valid   in   1   operation presented on InputA/InputB/OP
//  in_ready   out  1   block can accept an operation this cycle
//  InputA     in   W   operand A (Reg1)
//  InputB     in   W   operand B (Reg2 / immediate / LUT value)
//  OP         in   4   opcode, see BEHAVIOUR
//  out_valid  out  1   Out and flags hold a finished result
//  out_ready  in   1   consumer takes the result this cycle
//  Out        out  W   result, registered
//  Zero       out  1   zero / equality flag, registered
//  Carry      out  1   carry / no-borrow / multiply-overflow flag, registered
//  Err        out  1   reserved opcode was executed, registered
// BEHAVIOUR
//  Opcodes:
//   0 XOR: A^B.   1 RXOR: {W-1'b0, ^B}.   2 OR: A|B.   3 BEQ: Out=0, Zero=(A==B).
//   4 AND: A&B.   5 MA: Out=0.   6 BS: shift A by B[SW-1:0]; right if B[SW]=1,
//   else left; zero-fill.   7 ADD: A+B, Carry=carry-out.   8 SUB: A-B,
//   Carry=(A>=B).   9 MUL: low W bits of A*B, Carry=(high W bits!=0).
//   10-15 reserved: Out=0, Err=1.
//  Flags:
//   Zero=(Out==0) for every op except BEQ.
//   Carry=0 for ops other than ADD/SUB/MUL.
//   Err=0 for every defined op.
//  FSM states: IDLE, BUSY, DONE.
//   Accept = in_valid && in_ready at a rising edge; operands and OP are captured then.
//   in_ready = Reset_n && (state==IDLE || (state==DONE && out_ready)).
//  Latency L (edges from the accepting edge to out_valid high):
//   1 for ops 0-5, 7, 8, 10-15.   BS: max(1, shamt).   MUL: W (one add-shift per cycle).
//  Transitions:
//   L==1: accept -> DONE.
//   Otherwise: accept -> BUSY with counter = L-1. Each BUSY edge does one step
//   (1-bit shift or one multiply iteration) and decrements; the final step -> DONE.
//  DONE:
//   - out_valid=1.
//   - Out/flags held stable while out_ready=0.
//   - out_ready=1 with no new accept -> IDLE.
//   - out_ready=1 with in_valid=1 -> result retired and new op accepted on the same
//     edge (next state per new op's L). Zero-bubble back-to-back.
//  Inputs are ignored while BUSY. InputA/InputB/OP may change freely after the accept.
//  Out/flags change only on the edge that enters DONE.
//  Reset:
//   - Reset_n low (any time, including mid-BUSY) immediately forces IDLE.
//   - Out=0, Zero=0, Carry=0, Err=0, out_valid=0, in_ready=0.
//   - An in-flight op is discarded.
//   - in_ready rises combinationally once Reset_n is high.
//  Arithmetic is W-bit unsigned, wrap-around. The internal MUL accumulator is 2W bits.
// TESTING
//  1 ADD A=8'hF0 B=8'h20 -> out_valid 1 edge after accept, Out=8'h10, Carry=1, Zero=0.
//  2 BS A=8'h80 B=8'h0B (right, 3) -> Out=8'h10 after 3 edges. B=8'h00 -> Out=8'h80
//    after 1 edge. BEQ 5,5 -> Zero=1, Out=0.
//  3 MUL 13*11 -> Out=8'h8F, Carry=0 at edge 8. MUL 20*20 -> Out=8'h90, Carry=1.
//  4 Hold out_ready=0 for 5 cycles in DONE -> Out stable, in_ready=0. Then out_ready=1
//    with in_valid=1 (XOR 8'hAA,8'h55) -> accepted same edge; next cycle Out=8'hFF.
//  5 Drop Reset_n at BUSY cycle 4 of a MUL -> all outputs 0 asynchronously. After
//    release, in_ready=1 and the next ADD 1+1 gives Out=2.
//  6 OP=4'hC -> Out=0, Err=1, Zero=1. Next defined op clears Err.

Source files
------------

// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU: single-cycle logic ops, serial barrel shift and
// shift-add multiply, with registered result and Zero/Carry/Err flags.
module alu_multicycle #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    input  logic [3:0]   OP,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Out,
    output logic         Zero,
    output logic         Carry,
    output logic         Err
);
    localparam int SW = $clog2(W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [3:0] {
        OP_XOR = 4'd0, OP_RXOR = 4'd1, OP_OR  = 4'd2, OP_BEQ = 4'd3,
        OP_AND = 4'd4, OP_MA   = 4'd5, OP_BS  = 4'd6, OP_ADD = 4'd7,
        OP_SUB = 4'd8, OP_MUL  = 4'd9
    } opcode_t;

    state_t          state;
    logic [SW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;
    logic            is_mul;
    logic            dir_q;

    logic            accept;
    logic [SW-1:0]   shamt;
    logic            dir;
    logic [W-1:0]    a_sh1;
    logic [W:0]      sum;
    logic            multi;
    logic [W-1:0]    res;
    logic            res_zero;
    logic            res_carry;
    logic            res_err;
    logic [2*W-1:0]  mul_next;
    logic [W-1:0]    sh_next;

    assign in_ready  = Reset_n && (state == IDLE || (state == DONE && out_ready));
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        shamt     = InputB[SW-1:0];
        dir       = InputB[SW];
        a_sh1     = dir ? (InputA >> 1) : (InputA << 1);
        sum       = {1'b0, InputA} + {1'b0, InputB};
        multi     = (OP == OP_MUL) || (OP == OP_BS && shamt > SW'(1));
        res       = '0;
        res_carry = 1'b0;
        res_err   = 1'b0;
        case (OP)
            OP_XOR:  res = InputA ^ InputB;
            OP_RXOR: res[0] = ^InputB;
            OP_OR:   res = InputA | InputB;
            OP_BEQ:  res = '0;
            OP_AND:  res = InputA & InputB;
            OP_MA:   res = '0;
            OP_BS:   res = (shamt == '0) ? InputA : a_sh1;
            OP_ADD: begin
                res       = sum[W-1:0];
                res_carry = sum[W];
            end
            OP_SUB: begin
                res       = InputA - InputB;
                res_carry = (InputA >= InputB);
            end
            OP_MUL:  res = '0;
            default: res_err = 1'b1;
        endcase
        res_zero = (OP == OP_BEQ) ? (InputA == InputB) : (res == '0);
    end

    // One multiply iteration / one 1-bit shift per BUSY edge.
    always_comb begin
        mul_next = acc + (mplier[0] ? mcand : '0);
        sh_next  = dir_q ? (acc[W-1:0] >> 1) : (acc[W-1:0] << 1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            is_mul <= 1'b0;
            dir_q  <= 1'b0;
            Out    <= '0;
            Zero   <= 1'b0;
            Carry  <= 1'b0;
            Err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (multi) begin
                            // The accepting edge already performs the first step.
                            state  <= BUSY;
                            is_mul <= (OP == OP_MUL);
                            dir_q  <= dir;
                            if (OP == OP_MUL) begin
                                acc    <= InputB[0] ? {{W{1'b0}}, InputA} : '0;
                                mcand  <= {{W{1'b0}}, InputA} << 1;
                                mplier <= InputB >> 1;
                                cnt    <= SW'(W - 1);
                            end else begin
                                acc    <= {{W{1'b0}}, a_sh1};
                                cnt    <= shamt - SW'(1);
                            end
                        end else begin
                            state <= DONE;
                            Out   <= res;
                            Zero  <= res_zero;
                            Carry <= res_carry;
                            Err   <= res_err;
                        end
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (is_mul) begin
                        acc    <= mul_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        acc <= {{W{1'b0}}, sh_next};
                    end
                    if (cnt == SW'(1)) begin
                        state <= DONE;
                        Err   <= 1'b0;
                        if (is_mul) begin
                            Out   <= mul_next[W-1:0];
                            Zero  <= (mul_next[W-1:0] == '0);
                            Carry <= |mul_next[2*W-1:W];
                        end else begin
                            Out   <= sh_next;
                            Zero  <= (sh_next == '0);
                            Carry <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (W=8).
module tb_alu_multicycle;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic [3:0] OP;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Out;
    logic       Zero;
    logic       Carry;
    logic       Err;

    int checks   = 0;
    int failures = 0;
    int lat;

    alu_multicycle #(.W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .InputA(InputA), .InputB(InputB), .OP(OP), .out_valid(out_valid),
        .out_ready(out_ready), .Out(Out), .Zero(Zero), .Carry(Carry), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents an op at a falling edge, scrambles operands after the accept,
    // and measures edges until out_valid (bounded).
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int l);
        OP = op; InputA = a; InputB = b; in_valid = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        InputA = 8'($urandom); InputB = 8'($urandom); OP = 4'($urandom);
        l = 1;
        while (!out_valid && l < 40) begin
            @(negedge Clk);
            l++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int l, input int l_exp, input logic [7:0] o,
                           input logic z, input logic c, input logic e);
        chk({tag, ".lat"}, l, l_exp);
        chk({tag, ".out"}, Out, o);
        chk({tag, ".zero"}, Zero, z);
        chk({tag, ".carry"}, Carry, c);
        chk({tag, ".err"}, Err, e);
    endtask

    initial begin
        Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        InputA = '0; InputB = '0; OP = '0;
        #2;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.flags", {Out, Zero, Carry, Err}, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        chk("post_rst.in_ready", in_ready, 1);

        run_op(4'd7, 8'hF0, 8'h20, lat);
        chk_res("add_carry", lat, 1, 8'h10, 0, 1, 0);
        retire();
        chk("retire.out_valid", out_valid, 0);

        run_op(4'd6, 8'h80, 8'h0B, lat);
        chk_res("bs_r3", lat, 3, 8'h10, 0, 0, 0);
        retire();
        run_op(4'd6, 8'h80, 8'h00, lat);
        chk_res("bs_0", lat, 1, 8'h80, 0, 0, 0);
        retire();
        run_op(4'd6, 8'h03, 8'h02, lat);
        chk_res("bs_l2", lat, 2, 8'h0C, 0, 0, 0);
        retire();
        run_op(4'd6, 8'h01, 8'h07, lat);
        chk_res("bs_l7", lat, 7, 8'h80, 0, 0, 0);
        retire();
        run_op(4'd6, 8'h81, 8'h09, lat);
        chk_res("bs_r1", lat, 1, 8'h40, 0, 0, 0);
        retire();
        run_op(4'd3, 8'h05, 8'h05, lat);
        chk_res("beq_eq", lat, 1, 8'h00, 1, 0, 0);
        retire();
        run_op(4'd3, 8'h05, 8'h06, lat);
        chk_res("beq_ne", lat, 1, 8'h00, 0, 0, 0);
        retire();

        run_op(4'd9, 8'd13, 8'd11, lat);
        chk_res("mul_13x11", lat, 8, 8'h8F, 0, 0, 0);
        retire();
        run_op(4'd9, 8'd20, 8'd20, lat);
        chk_res("mul_20x20", lat, 8, 8'h90, 0, 1, 0);
        retire();
        run_op(4'd9, 8'd16, 8'd16, lat);
        chk_res("mul_16x16", lat, 8, 8'h00, 1, 1, 0);
        retire();

        run_op(4'd8, 8'd5, 8'd7, lat);
        chk_res("sub_borrow", lat, 1, 8'hFE, 0, 0, 0);
        retire();
        run_op(4'd8, 8'd7, 8'd7, lat);
        chk_res("sub_eq", lat, 1, 8'h00, 1, 1, 0);
        retire();
        run_op(4'd1, 8'h00, 8'h07, lat);
        chk_res("rxor", lat, 1, 8'h01, 0, 0, 0);
        retire();
        run_op(4'd2, 8'hA0, 8'h05, lat);
        chk_res("or", lat, 1, 8'hA5, 0, 0, 0);
        retire();
        run_op(4'd4, 8'hF0, 8'h3C, lat);
        chk_res("and", lat, 1, 8'h30, 0, 0, 0);
        retire();
        run_op(4'd5, 8'hFF, 8'hFF, lat);
        chk_res("ma", lat, 1, 8'h00, 1, 0, 0);
        retire();

        run_op(4'd7, 8'd1, 8'd2, lat);
        chk_res("hold_add", lat, 1, 8'h03, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("hold.out", Out, 8'h03);
            chk("hold.out_valid", out_valid, 1);
            chk("hold.in_ready", in_ready, 0);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        OP = 4'd0; InputA = 8'hAA; InputB = 8'h55;
        #1;
        chk("b2b.in_ready", in_ready, 1);
        @(negedge Clk);
        in_valid = 1'b0;
        chk("b2b.out_valid", out_valid, 1);
        chk("b2b.out", Out, 8'hFF);
        chk("b2b.zero", Zero, 0);
        @(negedge Clk);
        out_ready = 1'b0;
        chk("b2b.idle", out_valid, 0);

        OP = 4'd9; InputA = 8'd13; InputB = 8'd11; in_valid = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (3) @(negedge Clk);
        chk("midbusy.out_valid", out_valid, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst.out", Out, 8'h00);
        chk("async_rst.flags", {Zero, Carry, Err}, 0);
        chk("async_rst.out_valid", out_valid, 0);
        chk("async_rst.in_ready", in_ready, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        chk("rel.in_ready", in_ready, 1);
        chk("rel.out_valid", out_valid, 0);
        @(negedge Clk);
        run_op(4'd7, 8'd1, 8'd1, lat);
        chk_res("add_after_rst", lat, 1, 8'h02, 0, 0, 0);
        retire();

        run_op(4'hC, 8'h12, 8'h34, lat);
        chk_res("reserved", lat, 1, 8'h00, 1, 0, 1);
        retire();
        run_op(4'hF, 8'hFF, 8'hFF, lat);
        chk_res("reserved_f", lat, 1, 8'h00, 1, 0, 1);
        retire();
        run_op(4'd7, 8'd3, 8'd4, lat);
        chk_res("err_clear", lat, 1, 8'h07, 0, 0, 0);
        retire();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
